// File: rtl/crc_sig_compactor_if.sv
// Bundle of the compactor's control, data and status signals.
// The bench drives the master side; crc_sig_compactor takes the slave side.
interface crc_sig_compactor_if;
  logic        start;
  logic        din_valid;
  logic [31:0] din;
  logic [31:0] golden;
  logic        unload;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] sig;
  logic        so;

  modport master (
    output start, din_valid, din, golden, unload,
    input  busy, done, pass, sig, so
  );

  modport slave (
    input  start, din_valid, din, golden, unload,
    output busy, done, pass, sig, so
  );
endinterface

// File: rtl/crc_sig_compactor.sv
// 32-bit MISR (x^32 + x^15 + x^10 + x^3 + 1) over a WINDOW-word run, then golden compare.
// Define CRC_SIG_UNLOAD_EN to add the 32-cycle MSB-first serial unload of the signature.
module crc_sig_compactor #(
  parameter int unsigned WINDOW = 256,
  parameter logic [31:0] SEED   = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  crc_sig_compactor_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPACT = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
`ifdef CRC_SIG_UNLOAD_EN
  localparam logic [1:0] S_UNLOAD  = 2'd3;
`endif

  // Feedback taps for x^15, x^10, x^3 and 1; x^32 is the shift-out bit itself.
  localparam logic [31:0] POLY        = 32'h0000_8409;
  localparam logic [15:0] WINDOW_LAST = 16'(WINDOW);

  logic [1:0]  state;
  logic [31:0] sig_q;
  logic [15:0] word_cnt;
  logic        done_q;
  logic        pass_q;

  logic [31:0] misr_next;
  logic [15:0] word_cnt_inc;
  logic        window_hit;

`ifdef CRC_SIG_UNLOAD_EN
  logic        so_q;
  logic [5:0]  shift_cnt;
  logic        checked;
`endif

  always_comb begin
    misr_next    = {sig_q[30:0], 1'b0} ^ bus.din ^ (sig_q[31] ? POLY : 32'h0);
    word_cnt_inc = word_cnt + 16'd1;
    window_hit   = (word_cnt_inc == WINDOW_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sig_q    <= 32'h0;
      word_cnt <= 16'h0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
`ifdef CRC_SIG_UNLOAD_EN
      so_q      <= 1'b0;
      shift_cnt <= 6'd0;
      checked   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        // Abort whatever is running, including a pending CHECK, and restart the window.
        state    <= S_COMPACT;
        sig_q    <= SEED;
        word_cnt <= 16'h0;
        pass_q   <= 1'b0;
`ifdef CRC_SIG_UNLOAD_EN
        so_q      <= 1'b0;
        shift_cnt <= 6'd0;
`endif
      end else begin
        case (state)
          S_COMPACT: begin
            if (bus.din_valid) begin
              sig_q    <= misr_next;
              word_cnt <= word_cnt_inc;
              if (window_hit) state <= S_CHECK;
            end
          end
          S_CHECK: begin
            pass_q <= (sig_q == bus.golden);
            done_q <= 1'b1;
            state  <= S_IDLE;
`ifdef CRC_SIG_UNLOAD_EN
            checked <= 1'b1;
`endif
          end
`ifdef CRC_SIG_UNLOAD_EN
          S_UNLOAD: begin
            // The accepting edge made shift 1; the state holds for 32 cycles in total.
            if (shift_cnt == 6'd32) begin
              state <= S_IDLE;
              so_q  <= 1'b0;
            end else begin
              so_q      <= sig_q[31];
              sig_q     <= {sig_q[30:0], sig_q[31]};
              shift_cnt <= shift_cnt + 6'd1;
            end
          end
`endif
          default: begin
`ifdef CRC_SIG_UNLOAD_EN
            if (bus.unload && checked) begin
              state     <= S_UNLOAD;
              so_q      <= sig_q[31];
              sig_q     <= {sig_q[30:0], sig_q[31]};
              shift_cnt <= 6'd1;
            end
`endif
          end
        endcase
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.sig  = sig_q;
`ifdef CRC_SIG_UNLOAD_EN
  assign bus.so   = so_q;
`else
  assign bus.so   = 1'b0;
`endif

endmodule

// File: tb/tb_crc_sig_compactor.sv
// Scoreboard bench for crc_sig_compactor: two instances (WINDOW=4/SEED=0 and WINDOW=1/SEED=MSB).
// Stimulus pushes the expected DONE result and cycle; per-instance monitors pop on DONE.
module tb_crc_sig_compactor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  crc_sig_compactor_if bus4 ();
  crc_sig_compactor_if bus1 ();

  crc_sig_compactor #(.WINDOW(4), .SEED(32'h0000_0000)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  crc_sig_compactor #(.WINDOW(1), .SEED(32'h8000_0000)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic        pass;
    logic [31:0] sig;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start4();
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
  endtask

  // One accepted word on the WINDOW=4 instance; 'last' queues the DONE result due in two cycles.
  task automatic word4(input logic [31:0] d, input logic [31:0] e, input bit last, input logic p);
    bus4.din_valid = 1'b1;
    bus4.din       = d;
    if (last) q4.push_back('{p, e, cycle + 2});
    step();
    bus4.din_valid = 1'b0;
    bus4.din       = 32'h0;
    check("sig4 after word", bus4.sig, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q4.size() == 0 && q1.size() == 0) break;
      step();
    end
    check("pending DONE results", 32'(q4.size() + q1.size()), 32'h0);
  endtask

  // A run that ends with SIG=0x8409 and PASS=1, used as the unload source.
  task automatic pass_run_8409();
    bus4.golden = 32'h0000_8409;
    start4();
    word4(32'h0, 32'h0, 1'b0, 1'b0);
    word4(32'h0, 32'h0, 1'b0, 1'b0);
    word4(32'h0, 32'h0, 1'b0, 1'b0);
    word4(32'h0000_8409, 32'h0000_8409, 1'b1, 1'b1);
    drain();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus4.done) begin
      if (q4.size() == 0) begin
        check("done4 with no pending result", {31'b0, bus4.done}, 32'h0);
      end else begin
        e = q4.pop_front();
        check("pass4 at DONE", {31'b0, bus4.pass}, {31'b0, e.pass});
        check("sig4 at DONE", bus4.sig, e.sig);
        check("done4 cycle", cycle, e.cyc);
      end
    end
    if (bus1.done) begin
      if (q1.size() == 0) begin
        check("done1 with no pending result", {31'b0, bus1.done}, 32'h0);
      end else begin
        e = q1.pop_front();
        check("pass1 at DONE", {31'b0, bus1.pass}, {31'b0, e.pass});
        check("sig1 at DONE", bus1.sig, e.sig);
        check("done1 cycle", cycle, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ref_w;
    bus4.start = 1'b0; bus4.din_valid = 1'b0; bus4.din = 32'h0; bus4.golden = 32'h0; bus4.unload = 1'b0;
    bus1.start = 1'b0; bus1.din_valid = 1'b0; bus1.din = 32'h0; bus1.golden = 32'h0; bus1.unload = 1'b0;

    repeat (3) step();
    check("reset sig4", bus4.sig, 32'h0);
    check("reset busy4", {31'b0, bus4.busy}, 32'h0);
    check("reset pass4", {31'b0, bus4.pass}, 32'h0);
    check("reset done4", {31'b0, bus4.done}, 32'h0);
    check("reset so4", {31'b0, bus4.so}, 32'h0);
    rst_n = 1'b1;
    step();

    // Basic window: 1,0,0,0 -> 1,2,4,8; golden 8.
    bus4.golden = 32'h8;
    start4();
    check("busy4 after START", {31'b0, bus4.busy}, 32'h1);
    check("sig4 = SEED", bus4.sig, 32'h0);
    word4(32'h1, 32'h1, 1'b0, 1'b0);
    word4(32'h0, 32'h2, 1'b0, 1'b0);
    word4(32'h0, 32'h4, 1'b0, 1'b0);
    word4(32'h0, 32'h8, 1'b1, 1'b1);
    drain();
    check("pass4 held", {31'b0, bus4.pass}, 32'h1);
    check("busy4 idle", {31'b0, bus4.busy}, 32'h0);

    // Feedback path: WINDOW=1, SEED=MSB, DIN=0 -> 0x8409, golden 0x8408 fails.
    bus1.golden = 32'h0000_8408;
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    check("sig1 = SEED", bus1.sig, 32'h8000_0000);
    bus1.din_valid = 1'b1;
    bus1.din = 32'h0;
    q1.push_back('{1'b0, 32'h0000_8409, cycle + 2});
    step();
    bus1.din_valid = 1'b0;
    check("sig1 after word", bus1.sig, 32'h0000_8409);
    drain();
    check("pass1 held low", {31'b0, bus1.pass}, 32'h0);

    // Gapped window: garbage DIN with DIN_VALID low must not be absorbed.
    start4();
    check("pass4 cleared by START", {31'b0, bus4.pass}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        word4((i == 0) ? 32'h1 : 32'h0, 32'h1 << (i / 2), i == 6, 1'b1);
      end else begin
        bus4.din = 32'hDEAD_BEEF;
        step();
        bus4.din = 32'h0;
        check("sig4 hold on gap", bus4.sig, 32'h1 << (i / 2));
      end
    end
    drain();

    // Restart after two words, then a full feedback-exercising window.
    bus4.golden = 32'h0002_1024;
    start4();
    word4(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    word4(32'h0, 32'h0000_8409, 1'b0, 1'b0);
    start4();
    check("sig4 back to SEED", bus4.sig, 32'h0);
    word4(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    word4(32'h0, 32'h0000_8409, 1'b0, 1'b0);
    word4(32'h0, 32'h0001_0812, 1'b0, 1'b0);
    check("busy4 before last word", {31'b0, bus4.busy}, 32'h1);
    word4(32'h0, 32'h0002_1024, 1'b1, 1'b1);
    drain();
    check("pass4 after restart run", {31'b0, bus4.pass}, 32'h1);

    // START during the CHECK cycle: no DONE, PASS cleared.
    start4();
    word4(32'h1, 32'h1, 1'b0, 1'b0);
    word4(32'h0, 32'h2, 1'b0, 1'b0);
    word4(32'h0, 32'h4, 1'b0, 1'b0);
    word4(32'h0, 32'h8, 1'b0, 1'b0);
    start4();
    check("pass4 cleared in CHECK", {31'b0, bus4.pass}, 32'h0);
    check("busy4 restarted", {31'b0, bus4.busy}, 32'h1);
    check("sig4 SEED after CHECK abort", bus4.sig, 32'h0);
    repeat (3) step();

    pass_run_8409();
    ref_w = 32'h0000_8409;
    bus4.unload = 1'b1;
    step();
    bus4.unload = 1'b0;
`ifdef CRC_SIG_UNLOAD_EN
    for (int k = 0; k < 32; k++) begin
      check("so4 stream bit", {31'b0, bus4.so}, {31'b0, ref_w[31 - k]});
      check("busy4 in unload", {31'b0, bus4.busy}, 32'h1);
      step();
    end
    check("busy4 after unload", {31'b0, bus4.busy}, 32'h0);
    check("sig4 restored after unload", bus4.sig, ref_w);
`else
    check("busy4 unload ignored", {31'b0, bus4.busy}, 32'h0);
    check("so4 tied low", {31'b0, bus4.so}, 32'h0);
    step();
    check("sig4 unchanged by unload", bus4.sig, ref_w);
`endif

    // Asynchronous reset mid-COMPACT.
    start4();
    word4(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("sig4 reset mid-compact", bus4.sig, 32'h0);
    check("busy4 reset mid-compact", {31'b0, bus4.busy}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-UNLOAD (PASS high beforehand).
    pass_run_8409();
    bus4.unload = 1'b1;
    step();
    bus4.unload = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("sig4 reset mid-unload", bus4.sig, 32'h0);
    check("busy4 reset mid-unload", {31'b0, bus4.busy}, 32'h0);
    check("pass4 reset mid-unload", {31'b0, bus4.pass}, 32'h0);
    check("so4 reset mid-unload", {31'b0, bus4.so}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // UNLOAD before any CHECK after reset must be ignored.
    bus4.unload = 1'b1;
    step();
    bus4.unload = 1'b0;
    check("busy4 unload before CHECK", {31'b0, bus4.busy}, 32'h0);
    check("so4 unload before CHECK", {31'b0, bus4.so}, 32'h0);
    step();
    check("sig4 idle after ignored unload", bus4.sig, 32'h0);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
